// File: rtl/calculation_pkg.sv
// calculation: shared op/state encodings and derived-width helpers for the calculation unit.
package calculation;
  typedef enum logic [2:0] {ADD, SUB, MUL, DIV, SQRT} calc_op_t;
  typedef enum logic [1:0] {IDLE, MUL_WAIT, ITERATE, HOLD} calc_state_t;
  function automatic int a_w(input int f);
    return f + 1;
  endfunction
  function automatic int b_w(input int f);
    return 2 * f + 3;
  endfunction
  function automatic int q_w(input int f);
    return f + 3;
  endfunction
  function automatic int r_w(input int f);
    return f + 4;
  endfunction
endpackage

// File: rtl/calculation_unit_param_div_sqrt.sv
// div_sqrt_iter: radix-2 restoring divider / square root, one result bit per cycle.
module div_sqrt_iter import calculation::*; #(
  parameter int F = 23
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                abort,
  input  logic                start,
  input  logic                sqrt_mode,
  input  logic [F+1:0]        dividend,
  input  logic [F+1:0]        divisor,
  input  logic [q_w(F)-1:0]   radicand,
  output logic                done,
  output logic [q_w(F)-1:0]   q,
  output logic [r_w(F)-1:0]   rem
);
  localparam int QW = q_w(F);
  localparam int RW = r_w(F);
  localparam int IW = RW + 2;
  localparam int CW = $clog2(QW);
  logic          busy, mode, dbz, hit;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rem_q;
  logic [IW-1:0] dvs, cur, trial, diff, keep;
  logic [QW-1:0] q_q, rad;
  // q and rem are the values after this cycle's step, so the caller can latch them on done
  always_comb begin
    cur = mode ? {rem_q, rad[QW-1 -: 2]} : IW'(rem_q);
    trial = mode ? {1'b0, q_q, 2'b01} : dvs;
    diff = cur - trial;
    hit = dbz | (cur >= trial);
    keep = hit ? diff : cur;
    done = busy & (cnt == '0);
    q = {q_q[QW-2:0], hit};
    rem = dbz ? rem_q : RW'((mode | done) ? keep : keep << 1);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy <= 1'b0;
      mode <= 1'b0;
      dbz <= 1'b0;
      cnt <= '0;
      rem_q <= '0;
      dvs <= '0;
      q_q <= '0;
      rad <= '0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
      mode <= sqrt_mode;
      dbz <= !sqrt_mode && divisor == '0;
      cnt <= CW'(QW - 1);
      rem_q <= sqrt_mode ? '0 : RW'(dividend);
      dvs <= IW'(divisor);
      q_q <= '0;
      rad <= radicand;
    end else if (busy) begin
      busy <= !done;
      cnt <= cnt - 1'b1;
      rem_q <= rem;
      q_q <= q;
      rad <= rad << 2;
    end
  end
endmodule

// File: rtl/calculation_unit_param.sv
// calculation_unit_param: exponent/fraction arithmetic for add, sub, mul, div, sqrt
// with valid/ready handshake, pipelined multiplier and iterative div/sqrt engine.
module calculation_unit_param import calculation::*; #(
  parameter int EXP_W      = 8,
  parameter int FRAC_W     = 23,
  parameter int BIAS       = 127,
  parameter int MUL_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  calc_op_t                      op,
  input  logic [EXP_W-1:0]              exp_a,
  input  logic [a_w(FRAC_W)-1:0]        frac_a,
  input  logic [EXP_W-1:0]              exp_b,
  input  logic [b_w(FRAC_W)-1:0]        frac_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [EXP_W+1:0]       result_exp,
  output logic [b_w(FRAC_W)-1:0]        result_frac,
  output logic [r_w(FRAC_W)-1:0]        remainder,
  output logic                          div_by_zero
);
  localparam int F = FRAC_W;
  localparam int AW = a_w(F);
  localparam int BW = b_w(F);
  localparam int QW = q_w(F);
  localparam int RW = r_w(F);
  localparam int XW = EXP_W + 2;
  localparam int MCW = $clog2(MUL_STAGES) + 1;
  calc_state_t state, state_n;
  logic [MCW-1:0] mcnt;
  logic accept, mul_load, eng_start, eng_done;
  logic [QW-1:0] eng_q;
  logic [RW-1:0] eng_rem;
  logic signed [XW-1:0] ea, eb, exp_n;
  logic [BW-1:0] frac_n, mul_now, mul_res;
  logic [2*AW-1:0] prod;
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == HOLD;
    accept = in_valid & in_ready & ~flush;
    eng_start = accept & (op == DIV || op == SQRT);
    mul_load = (state == MUL_WAIT && mcnt == '0) || (accept && op == MUL && MUL_STAGES == 1);
    state_n = flush ? IDLE :
              state == IDLE ? (!accept ? IDLE :
                               op inside {ADD, SUB} ? HOLD :
                               op == MUL ? (MUL_STAGES == 1 ? HOLD : MUL_WAIT) : ITERATE) :
              state == MUL_WAIT ? (mcnt == '0 ? HOLD : MUL_WAIT) :
              state == ITERATE ? (eng_done ? HOLD : ITERATE) :
              out_ready ? IDLE : HOLD;
  end
  always_comb begin
    ea = {2'b00, exp_a};
    eb = {2'b00, exp_b};
    exp_n = op == MUL ? ea + eb - XW'(BIAS) :
            op == DIV ? ea - eb + XW'(BIAS) : ea;
    frac_n = op == ADD ? (BW'(frac_a) << (F + 1)) + frac_b :
             op == SUB ? (BW'(frac_a) << (F + 1)) - frac_b : '0;
    prod = (2*AW)'(frac_a) * (2*AW)'(frac_b[2*F+1:F+1]);
    mul_now = {prod, 1'b0};
  end
  // Product enters the pipe every cycle; the FSM picks it up when the accepted op reaches the last stage
  generate
    if (MUL_STAGES == 1) begin : g_mul_comb
      assign mul_res = mul_now;
    end else begin : g_mul_pipe
      logic [BW-1:0] pipe [MUL_STAGES-1];
      always_ff @(posedge clk) begin
        pipe[0] <= mul_now;
        for (int i = 1; i < MUL_STAGES - 1; i++) pipe[i] <= pipe[i-1];
      end
      assign mul_res = pipe[MUL_STAGES-2];
    end
  endgenerate
  div_sqrt_iter #(.F(F)) u_iter (
    .clk(clk),
    .reset(reset),
    .abort(flush),
    .start(eng_start),
    .sqrt_mode(op == SQRT),
    .dividend({frac_a, 1'b0}),
    .divisor(frac_b[2*F+1:F]),
    .radicand(frac_b[2*F+2:F]),
    .done(eng_done),
    .q(eng_q),
    .rem(eng_rem)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      mcnt <= '0;
      result_exp <= '0;
      result_frac <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        mcnt <= MCW'(MUL_STAGES > 1 ? MUL_STAGES - 2 : 0);
        result_exp <= exp_n;
        result_frac <= frac_n;
        remainder <= '0;
        div_by_zero <= op == DIV && frac_b[2*F+1:F] == '0;
      end else if (state == MUL_WAIT) begin
        mcnt <= mcnt - 1'b1;
      end
      if (mul_load) result_frac <= mul_res;
      if (state == ITERATE && eng_done) begin
        result_frac <= {1'b0, eng_q, {(F-1){1'b0}}};
        remainder <= eng_rem;
      end
    end
  end
endmodule

// File: tb/tb_calculation_unit_param.sv
// tb_calculation_unit_param: vector table, randomized ops against an arithmetic model, and handshake/flush/reset sequences.
module tb_calculation_unit_param;
  import calculation::*;
  logic clk = 0, reset = 0, flush = 0, in_valid = 0, out_ready = 0;
  calc_op_t op = ADD;
  logic [7:0] exp_a = 0, exp_b = 0;
  logic [23:0] frac_a = 0;
  logic [48:0] frac_b = 0;
  logic in_ready, out_valid, div_by_zero;
  logic signed [9:0] result_exp;
  logic [48:0] result_frac;
  logic [26:0] remainder;
  int checks = 0, failures = 0;

  typedef struct {
    calc_op_t op; logic [7:0] ea, eb; logic [23:0] fa; logic [48:0] fb;
    logic [9:0] xe; logic [48:0] xf; logic [26:0] xr; logic xd;
  } vec_t;
  vec_t vecs [8];

  calculation_unit_param dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .exp_a(exp_a), .frac_a(frac_a), .exp_b(exp_b), .frac_b(frac_b),
    .out_valid(out_valid), .out_ready(out_ready), .result_exp(result_exp),
    .result_frac(result_frac), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input string field, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s.%s got=%0h want=%0h", tag, field, got, want);
    end
  endtask

  function automatic longint unsigned isqrt(input longint unsigned n);
    longint unsigned lo = 0, hi = 64'd1 << 26, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= n) lo = mid; else hi = mid;
    end
    return lo;
  endfunction

  function automatic void model(input calc_op_t o, input logic [7:0] ea, eb, input logic [23:0] fa,
                                input logic [48:0] fb, output logic [9:0] xe, output logic [48:0] xf,
                                output logic [26:0] xr, output logic xd);
    longint unsigned a = fa, b = fb, dd, dv, n, r;
    xe = 10'(ea); xr = 0; xd = 0; xf = 0;
    case (o)
      ADD: xf = 49'((a << 24) + b);
      SUB: xf = 49'((a << 24) - b);
      MUL: begin
        xe = 10'(32'(ea) + 32'(eb) - 127);
        xf = 49'((a * ((b >> 24) & 64'hFFFFFF)) << 1);
      end
      DIV: begin
        xe = 10'(32'(ea) - 32'(eb) + 127);
        dd = a << 1;
        dv = (b >> 23) & 64'h1FFFFFF;
        if (dv == 0) begin r = 64'h3FFFFFF; xr = 27'(dd); xd = 1; end
        else begin r = (dd << 25) / dv; xr = 27'((dd << 25) % dv); end
        xf = 49'(r << 22);
      end
      default: begin
        n = ((b >> 23) & 64'h3FFFFFF) << 26;
        r = isqrt(n);
        xr = 27'(n - r * r);
        xf = 49'(r << 22);
      end
    endcase
  endfunction

  task automatic issue(input calc_op_t o, input logic [7:0] ea, eb, input logic [23:0] fa, input logic [48:0] fb);
    op = o; exp_a = ea; exp_b = eb; frac_a = fa; frac_b = fb; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic run_op(input string tag, input vec_t v, input int hold);
    int lat = 1, busy_ready = 0, want_lat;
    want_lat = (v.op == ADD || v.op == SUB) ? 1 : v.op == MUL ? 2 : 27;
    chk(tag, "in_ready_idle", in_ready, 1);
    issue(v.op, v.ea, v.eb, v.fa, v.fb);
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ready++;
      @(posedge clk); #1;
      lat++;
    end
    chk(tag, "latency", lat, want_lat);
    chk(tag, "in_ready_busy", busy_ready, 0);
    repeat (hold) begin @(posedge clk); #1; end
    chk(tag, "exp", $unsigned(result_exp), v.xe);
    chk(tag, "frac", result_frac, v.xf);
    chk(tag, "rem", remainder, v.xr);
    chk(tag, "dbz", div_by_zero, v.xd);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  initial begin
    vec_t v;
    int seen;
    vecs[0] = '{ADD, 8'd127, 8'd0, 24'h800000, 49'h800000000000, 10'd127, 49'h1000000000000, 27'd0, 1'b0};
    vecs[1] = '{MUL, 8'd128, 8'd127, 24'hC00000, 49'hC00000000000, 10'd128, 49'h1200000000000, 27'd0, 1'b0};
    vecs[2] = '{DIV, 8'd127, 8'd127, 24'h800000, 49'h800000000000, 10'd127, 49'h0800000000000, 27'd0, 1'b0};
    vecs[3] = '{SQRT, 8'd127, 8'd0, 24'h800000, 49'h1200000000000, 10'd127, 49'h0C00000000000, 27'd0, 1'b0};
    vecs[4] = '{SUB, 8'd5, 8'd0, 24'h000000, 49'h1, 10'd5, 49'h1FFFFFFFFFFFF, 27'd0, 1'b0};
    vecs[5] = '{DIV, 8'd10, 8'd20, 24'hC00000, 49'h0, 10'd117, 49'h0FFFFFFC00000, 27'h1800000, 1'b1};
    vecs[6] = '{MUL, 8'd1, 8'd2, 24'h800000, 49'h800000000000, 10'h384, 49'h800000000000, 27'd0, 1'b0};
    vecs[7] = '{DIV, 8'd255, 8'd0, 24'hC00000, 49'h800000000000, 10'h17E, 49'h0C00000000000, 27'd0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset", "in_ready", in_ready, 1);
    chk("reset", "out_valid", out_valid, 0);
    chk("reset", "exp", $unsigned(result_exp), 0);
    chk("reset", "frac", result_frac, 0);
    chk("reset", "rem", remainder, 0);
    chk("reset", "dbz", div_by_zero, 0);
    reset = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_op($sformatf("vec%0d", i), vecs[i], i % 3);

    for (int i = 0; i < 40; i++) begin
      v.op = calc_op_t'($urandom_range(0, 4));
      v.ea = 8'($urandom); v.eb = 8'($urandom);
      v.fa = {1'b1, 23'($urandom)};
      v.fb = 49'({$urandom, $urandom});
      if (v.op == DIV) begin
        v.fb[48] = 0; v.fb[47] = 1;
        if ($urandom_range(0, 7) == 0) v.fb[47:23] = '0;
      end
      if (v.op == SQRT && v.fb[48:47] == 0) v.fb[47] = 1;
      model(v.op, v.ea, v.eb, v.fa, v.fb, v.xe, v.xf, v.xr, v.xd);
      run_op($sformatf("rnd%0d", i), v, $urandom_range(0, 3));
    end

    // result held while downstream stalls, then released
    issue(ADD, 8'd127, 8'd0, 24'h800000, 49'h800000000000);
    for (int i = 0; i < 5; i++) begin
      chk("hold", "out_valid", out_valid, 1);
      chk("hold", "in_ready", in_ready, 0);
      chk("hold", "frac", result_frac, 49'h1000000000000);
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("release", "out_valid", out_valid, 0);
    chk("release", "in_ready", in_ready, 1);

    // flush at T+10 of a divide
    issue(DIV, 8'd127, 8'd127, 24'h800000, 49'h800000000000);
    repeat (9) @(posedge clk);
    #1;
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("flush_div", "in_ready", in_ready, 1);
    chk("flush_div", "out_valid", out_valid, 0);
    seen = 0;
    repeat (30) begin @(posedge clk); #1; if (out_valid) seen++; end
    chk("flush_div", "late_valid", seen, 0);
    run_op("after_flush_dbz", vecs[5], 0);

    // flush beats in_valid in IDLE
    op = ADD; in_valid = 1; flush = 1;
    @(posedge clk); #1;
    in_valid = 0; flush = 0;
    chk("flush_prio", "in_ready", in_ready, 1);
    chk("flush_prio", "out_valid", out_valid, 0);

    // flush discards a held result
    issue(ADD, 8'd3, 8'd0, 24'h800000, 49'h1);
    chk("flush_hold", "valid_before", out_valid, 1);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("flush_hold", "out_valid", out_valid, 0);
    chk("flush_hold", "in_ready", in_ready, 1);

    // reset in the middle of an iteration
    issue(DIV, 8'd10, 8'd20, 24'hC00000, 49'h0);
    repeat (4) @(posedge clk);
    #1;
    reset = 0;
    @(posedge clk); #1;
    chk("reset_iter", "out_valid", out_valid, 0);
    chk("reset_iter", "in_ready", in_ready, 1);
    chk("reset_iter", "exp", $unsigned(result_exp), 0);
    chk("reset_iter", "frac", result_frac, 0);
    chk("reset_iter", "rem", remainder, 0);
    chk("reset_iter", "dbz", div_by_zero, 0);
    reset = 1;
    @(posedge clk); #1;
    run_op("after_reset", vecs[3], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
